fwd_hazard_ctrl: RTL
====================

Name: fwd_hazard_ctrl

Overview:
- Generates the select codes that drive the EX-stage operand muxes, plus the load-use stall control for the 5-stage RISC-V pipeline.
- Keeps its own shadow pipeline (EX/MEM/WB) of destination-register and control bits. From these it decides forwarding sources and inserts bubbles.
- Sits beside the ID/EX, EX/MEM and MEM/WB registers. The operand muxes consume its outputs directly as select inputs.

Parameters:
REG_AW, 5, register address width
CNT_W, 32, width of the stall performance counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
id_valid  input  1  instruction in ID is real, not a bubble
id_rs1  input  REG_AW  ID source register 1
id_rs2  input  REG_AW  ID source register 2
id_rd  input  REG_AW  ID destination register
id_reg_write  input  1  ID instruction writes rd
id_mem_read  input  1  ID instruction is a load
id_flush  input  1  branch/jump taken; squash the ID instruction
fwd_a_sel  output  2  EX operand A select: 00 regfile, 01 WB result, 10 MEM ALU result
fwd_b_sel  output  2  EX operand B select, same encoding
stall  output  1  load-use stall active this cycle
pc_write  output  1  PC update enable (= !stall)
if_id_write  output  1  IF/ID register enable (= !stall)
stall_count  output  CNT_W  saturating count of stall cycles

Behaviour:
Interface:
- One clock.
- reset is asynchronous and active-high.

State:
- ex_{rs1,rs2,rd,reg_write,mem_read}
- mem_{rd,reg_write}
- wb_{rd,reg_write}
- stall_count

Reset (async):
- All state clears to 0.
- Outputs at reset: fwd_a_sel=00, fwd_b_sel=00, stall=0, pc_write=1, if_id_write=1, stall_count=0.

Stall logic (combinational):
- raw_stall = id_valid & ex_mem_read & (ex_rd!=0) & (ex_rd==id_rs1 | ex_rd==id_rs2).
- stall = raw_stall & !id_flush. Flush wins; the squashed instruction needs no stall.

Clock edge, shadow pipeline advance:
- wb <= mem and mem <= ex, unconditionally every cycle.
- ex <= ID fields only when id_valid & !stall & !id_flush.
- Otherwise ex is loaded as a bubble: reg_write=0, mem_read=0, all addresses 0.

Forwarding (combinational from ex/mem/wb state), shown for A; B is identical using ex_rs2:
- 10 if mem_reg_write & mem_rd!=0 & mem_rd==ex_rs1.
- else 01 if wb_reg_write & wb_rd!=0 & wb_rd==ex_rs1.
- else 00.
- MEM has priority over WB, so the most recent producer wins.
- x0 is never forwarded.

Stall timing:
- A load-use stall lasts exactly one cycle. The bubble removes ex_mem_read on the next edge.
- The following cycle, the load is in MEM. The dependent instruction then gets 01 (WB) once it reaches EX.

stall_count:
- Increments by 1 on each edge where stall=1.
- Saturates at all-ones; no wrap.

Other boundaries:
- id_valid=0 never stalls and enters EX as a bubble.
- A load with rd=0 never stalls.
- Reset asserted mid-stall: stall drops immediately (async), the pipeline clears, and stall_count returns to 0.

Test Plan:
- Back-to-back ALU: add x5 (rd=5, rw=1), then sub using rs1=5 -> when sub reaches EX, fwd_a_sel=10, stall=0.
- Distance-2 dependency: add x6; nop; or with rs2=6 -> fwd_b_sel=01, fwd_a_sel=00.
- Double producer: add x7; add x7; use rs1=7 -> fwd_a_sel=10, so MEM beats WB.
- Load-use: ld x8 (mem_read=1); next instruction rs1=8 -> stall=1, pc_write=0, if_id_write=0 for exactly 1 cycle; stall_count 0->1; dependent instruction then gets fwd_a_sel=01.
- Load-use combined with id_flush=1 in the same cycle -> stall=0, EX receives a bubble, stall_count unchanged.
- x0 and reset: ld x0 then use rs1=0 -> no stall, sel=00. Asserting reset during a stall -> all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/fwd_hazard_ctrl.sv
// EX-stage operand forwarding selects and load-use stall control for a 5-stage pipeline.
// A shadow EX/MEM/WB pipeline of register addresses and control bits drives every decision.
module fwd_hazard_ctrl #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_flush,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              stall,
    output logic              pc_write,
    output logic              if_id_write,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_WB  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    logic [REG_AW-1:0] ex_rs1_q, ex_rs1_d;
    logic [REG_AW-1:0] ex_rs2_q, ex_rs2_d;
    logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
    logic              ex_reg_write_q, ex_reg_write_d;
    logic              ex_mem_read_q, ex_mem_read_d;
    logic [REG_AW-1:0] mem_rd_q, mem_rd_d;
    logic              mem_reg_write_q, mem_reg_write_d;
    logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
    logic              wb_reg_write_q, wb_reg_write_d;
    logic [CNT_W-1:0]  stall_count_q, stall_count_d;

    logic raw_stall;
    logic ex_load;

    // MEM beats WB so the youngest producer wins; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
        logic [1:0] sel;
        sel = SEL_RF;
        if (mem_reg_write_q && (mem_rd_q != '0) && (mem_rd_q == rs)) begin
            sel = SEL_MEM;
        end else if (wb_reg_write_q && (wb_rd_q != '0) && (wb_rd_q == rs)) begin
            sel = SEL_WB;
        end
        return sel;
    endfunction

    always_comb begin
        raw_stall = id_valid && ex_mem_read_q && (ex_rd_q != '0) &&
                    ((ex_rd_q == id_rs1) || (ex_rd_q == id_rs2));
        // A squashed instruction has no hazard to wait on.
        stall       = raw_stall && !id_flush;
        pc_write    = !stall;
        if_id_write = !stall;
        fwd_a_sel   = fwd_sel(ex_rs1_q);
        fwd_b_sel   = fwd_sel(ex_rs2_q);
        stall_count = stall_count_q;
    end

    always_comb begin
        ex_load         = id_valid && !stall && !id_flush;
        ex_rs1_d        = '0;
        ex_rs2_d        = '0;
        ex_rd_d         = '0;
        ex_reg_write_d  = 1'b0;
        ex_mem_read_d   = 1'b0;
        mem_rd_d        = ex_rd_q;
        mem_reg_write_d = ex_reg_write_q;
        wb_rd_d         = mem_rd_q;
        wb_reg_write_d  = mem_reg_write_q;
        stall_count_d   = stall_count_q;
        if (ex_load) begin
            ex_rs1_d       = id_rs1;
            ex_rs2_d       = id_rs2;
            ex_rd_d        = id_rd;
            ex_reg_write_d = id_reg_write;
            ex_mem_read_d  = id_mem_read;
        end
        if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_rs1_q        <= '0;
            ex_rs2_q        <= '0;
            ex_rd_q         <= '0;
            ex_reg_write_q  <= 1'b0;
            ex_mem_read_q   <= 1'b0;
            mem_rd_q        <= '0;
            mem_reg_write_q <= 1'b0;
            wb_rd_q         <= '0;
            wb_reg_write_q  <= 1'b0;
            stall_count_q   <= '0;
        end else begin
            ex_rs1_q        <= ex_rs1_d;
            ex_rs2_q        <= ex_rs2_d;
            ex_rd_q         <= ex_rd_d;
            ex_reg_write_q  <= ex_reg_write_d;
            ex_mem_read_q   <= ex_mem_read_d;
            mem_rd_q        <= mem_rd_d;
            mem_reg_write_q <= mem_reg_write_d;
            wb_rd_q         <= wb_rd_d;
            wb_reg_write_q  <= wb_reg_write_d;
            stall_count_q   <= stall_count_d;
        end
    end

endmodule
